// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator run monitor.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] CAUSE_NONE      = 3'd0;
    localparam logic [2:0] CAUSE_END_PC    = 3'd1;
    localparam logic [2:0] CAUSE_SYSCALL   = 3'd2;
    localparam logic [2:0] CAUSE_SELF_LOOP = 3'd3;
    localparam logic [2:0] CAUSE_TIMEOUT   = 3'd4;

    localparam logic [31:0] SYSCALL_WORD_DEF = 32'h0000_000C;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and load-one; holds at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_clr,
    input  logic         i_load1,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;
    logic [W-1:0] w_next;

    always_comb begin
        w_next = r_count;
        if (i_clr)
            w_next = '0;
        else if (i_load1)
            w_next = W'(1);
        else if (i_inc && (r_count != {W{1'b1}}))
            w_next = r_count + W'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_count <= '0;
        else
            r_count <= w_next;
    end

    assign o_count = r_count;

endmodule

// File: rtl/calc_run_monitor.sv
// Run-control / end-of-program monitor for the calc core: detects end-PC, exit syscall,
// self-loop and timeout. Define CALC_RUN_MONITOR_SIG_EN to add the o_signature output.
module calc_run_monitor
    import calc_pkg::*;
#(
    parameter int          PC_W          = 32,
    parameter int          CNT_W         = 32,
    parameter int          MAX_CYCLES    = 1000,
    parameter int          STALL_RETIRES = 4,
    parameter logic [31:0] SYSCALL_WORD  = SYSCALL_WORD_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_instr_valid,
    input  logic [PC_W-1:0]  i_pc,
    input  logic [31:0]      i_instr,
    input  logic [PC_W-1:0]  i_end_pc,
    input  logic             i_end_pc_en,
    output logic             o_busy,
    output logic             o_done,
    output logic [2:0]       o_halt_cause,
    output logic [CNT_W-1:0] o_cycle_count,
    output logic [CNT_W-1:0] o_retire_count,
`ifdef CALC_RUN_MONITOR_SIG_EN
    output logic [31:0]      o_signature,
`endif
    output logic [PC_W-1:0]  o_last_pc
);

    localparam int STALL_W = $clog2(STALL_RETIRES + 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [2:0]         r_cause;
    logic [2:0]         w_cause;
    logic [PC_W-1:0]    r_last_pc;
    logic [STALL_W-1:0] w_stall;
    logic               w_run;
    logic               w_start;
    logic               w_retire;
    logic               w_same_pc;

    assign w_run    = (r_state == RUN);
    assign w_start  = i_start && (r_state != RUN);
    assign w_retire = w_run && i_instr_valid;
    // A zero stall count means no retirement yet this run, so the first one always loads 1.
    assign w_same_pc = (w_stall != '0) && (i_pc == r_last_pc);

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_start),
        .i_load1 (1'b0),
        .i_inc   (w_run),
        .o_count (o_cycle_count)
    );

    sat_counter #(.W(CNT_W)) u_retire_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_start),
        .i_load1 (1'b0),
        .i_inc   (w_retire),
        .o_count (o_retire_count)
    );

    sat_counter #(.W(STALL_W)) u_stall_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_start),
        .i_load1 (w_retire && !w_same_pc),
        .i_inc   (w_retire && w_same_pc),
        .o_count (w_stall)
    );

    // "Next value equals limit" is tested on the current value, one below the limit.
    always_comb begin
        w_cause = CAUSE_NONE;
        if (w_run) begin
            if (i_instr_valid && i_end_pc_en && (i_pc == i_end_pc))
                w_cause = CAUSE_END_PC;
            else if (i_instr_valid && (i_instr == SYSCALL_WORD))
                w_cause = CAUSE_SYSCALL;
            else if (w_retire && w_same_pc && (w_stall == STALL_W'(STALL_RETIRES - 1)))
                w_cause = CAUSE_SELF_LOOP;
            else if (o_cycle_count == CNT_W'(MAX_CYCLES - 1))
                w_cause = CAUSE_TIMEOUT;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: if (i_start) w_state_next = RUN;
            RUN:        if (w_cause != CAUSE_NONE) w_state_next = DONE;
            default:    w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_cause   <= CAUSE_NONE;
            r_last_pc <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_start)
                r_cause <= CAUSE_NONE;
            else if (w_cause != CAUSE_NONE)
                r_cause <= w_cause;
            if (w_retire)
                r_last_pc <= i_pc;
        end
    end

`ifdef CALC_RUN_MONITOR_SIG_EN
    logic [31:0] r_sig;
    logic [31:0] w_pc32;

    assign w_pc32 = 32'(i_pc);

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_sig <= '0;
        else if (w_start)
            r_sig <= '0;
        else if (w_retire)
            r_sig <= {r_sig[30:0], r_sig[31]} ^ w_pc32 ^ i_instr;
    end

    assign o_signature = r_sig;
`endif

    assign o_busy       = (r_state == RUN);
    assign o_done       = (r_state == DONE);
    assign o_halt_cause = r_cause;
    assign o_last_pc    = r_last_pc;

endmodule

// File: tb/tb_calc_run_monitor.sv
// Randomized and directed bench for calc_run_monitor against a run-level reference model.
module tb_calc_run_monitor;

    localparam int MAXC  = 100;
    localparam int STALL = 4;
    localparam logic [31:0] SYS = 32'h0000_000C;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        i_clk = 1'b0;
    logic        i_reset, i_start, i_instr_valid, i_end_pc_en;
    logic [31:0] i_pc, i_instr, i_end_pc;
    logic        o_busy, o_done;
    logic [2:0]  o_halt_cause;
    logic [31:0] o_cycle_count, o_retire_count, o_last_pc;
`ifdef CALC_RUN_MONITOR_SIG_EN
    logic [31:0] o_signature;
    logic [31:0] sig_a;
`endif

    always #5 i_clk = ~i_clk;

    calc_run_monitor #(
        .PC_W(32), .CNT_W(32), .MAX_CYCLES(MAXC), .STALL_RETIRES(STALL), .SYSCALL_WORD(SYS)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_start        (i_start),
        .i_instr_valid  (i_instr_valid),
        .i_pc           (i_pc),
        .i_instr        (i_instr),
        .i_end_pc       (i_end_pc),
        .i_end_pc_en    (i_end_pc_en),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_halt_cause   (o_halt_cause),
        .o_cycle_count  (o_cycle_count),
        .o_retire_count (o_retire_count),
`ifdef CALC_RUN_MONITOR_SIG_EN
        .o_signature    (o_signature),
`endif
        .o_last_pc      (o_last_pc)
    );

    int vec  = 0;
    int errs = 0;

    // Per-cycle stimulus of one run; index j is RUN cycle j (1-based).
    logic        s_vld   [256];
    logic        s_start [256];
    logic [31:0] s_pc    [256];
    logic [31:0] s_instr [256];

    int          m_term, m_cause, m_cyc, m_ret;
    logic [31:0] m_last = 32'd0;
    logic [31:0] m_sig;
    int          term;

    task automatic clear_stim();
        for (int j = 0; j < 256; j++) begin
            s_vld[j] = 1'b0; s_start[j] = 1'b0; s_pc[j] = '0; s_instr[j] = '0;
        end
    endtask

    // Whole-run reference: walks the cycles and applies the termination rules in order.
    task automatic model();
        int   stall;
        bit   had;
        logic [31:0] prev;
        m_term = 0; m_cause = 0; m_cyc = 0; m_ret = 0; m_sig = '0;
        stall = 0; had = 0; prev = m_last;
        for (int j = 1; j <= MAXC; j++) begin
            m_cyc++;
            if (s_vld[j]) begin
                m_ret++;
                stall = (had && s_pc[j] == prev) ? stall + 1 : 1;
                had   = 1;
                prev  = s_pc[j];
                m_sig = {m_sig[30:0], m_sig[31]} ^ s_pc[j] ^ s_instr[j];
            end
            if (s_vld[j] && i_end_pc_en && s_pc[j] == i_end_pc) m_cause = 1;
            else if (s_vld[j] && s_instr[j] == SYS)              m_cause = 2;
            else if (s_vld[j] && stall == STALL)                 m_cause = 3;
            else if (m_cyc == MAXC)                              m_cause = 4;
            if (m_cause != 0) begin
                m_term = j;
                break;
            end
        end
        m_last = prev;
    endtask

    // Pulses start, then plays the stimulus until done rises or the cycle budget runs out.
    task automatic do_run(output int t);
        i_start = 1'b1; i_instr_valid = 1'b0;
        @(posedge i_clk); #1;
        t = 0;
        for (int j = 1; j <= MAXC + 5; j++) begin
            i_start       = s_start[j];
            i_instr_valid = s_vld[j];
            i_pc          = s_pc[j];
            i_instr       = s_instr[j];
            @(posedge i_clk); #1;
            if (o_done) begin
                t = j;
                break;
            end
        end
        i_start = 1'b0; i_instr_valid = 1'b0;
    endtask

    task automatic load_end_pc_prog();
        clear_stim();
        for (int j = 1; j <= 5; j++) begin
            s_vld[j] = 1'b1; s_pc[j] = 32'((j - 1) * 4); s_instr[j] = NOP;
        end
        i_end_pc = 32'h10; i_end_pc_en = 1'b1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_start = 1'b1; i_instr_valid = 1'b0;
        i_pc = '0; i_instr = '0; i_end_pc = '0; i_end_pc_en = 1'b0;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        vec++;
        if ({o_busy, o_done, o_halt_cause} !== 5'b0 || o_cycle_count !== 0 ||
            o_retire_count !== 0 || o_last_pc !== 0) begin
            errs++;
            $display("FAIL reset: busy=%b done=%b cause=%0d cyc=%0d ret=%0d last=%h, want all zero",
                     o_busy, o_done, o_halt_cause, o_cycle_count, o_retire_count, o_last_pc);
        end
        i_reset = 1'b0; i_start = 1'b0;
        m_last = '0;
    endtask

    task automatic test_end_pc();
        load_end_pc_prog();
        model();
        do_run(term);
        vec++;
        if (term !== 5 || o_halt_cause !== 3'd1 || o_retire_count !== 5 ||
            o_cycle_count !== 5 || o_last_pc !== 32'h10) begin
            errs++;
            $display("FAIL end_pc: term=%0d cause=%0d ret=%0d cyc=%0d last=%h, want 5 1 5 5 10",
                     term, o_halt_cause, o_retire_count, o_cycle_count, o_last_pc);
        end
        // DONE must hold even with retirements on the bus.
        i_instr_valid = 1'b1; i_pc = 32'h44; i_instr = SYS;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        i_instr_valid = 1'b0;
        vec++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_cycle_count !== 5 ||
            o_retire_count !== 5 || o_last_pc !== 32'h10 || o_halt_cause !== 3'd1) begin
            errs++;
            $display("FAIL done_hold: done=%b busy=%b cyc=%0d ret=%0d last=%h cause=%0d, want 1 0 5 5 10 1",
                     o_done, o_busy, o_cycle_count, o_retire_count, o_last_pc, o_halt_cause);
        end
    endtask

    task automatic test_syscall();
        clear_stim();
        for (int j = 1; j <= 3; j++) begin
            s_vld[j] = 1'b1; s_pc[j] = 32'((j - 1) * 4); s_instr[j] = NOP;
        end
        s_vld[4] = 1'b1; s_pc[4] = 32'hC; s_instr[4] = SYS;
        i_end_pc = 32'h100; i_end_pc_en = 1'b1;
        model();
        do_run(term);
        vec++;
        if (term !== 4 || o_halt_cause !== 3'd2 || o_retire_count !== 4 || o_last_pc !== 32'hC) begin
            errs++;
            $display("FAIL syscall: term=%0d cause=%0d ret=%0d last=%h, want 4 2 4 c",
                     term, o_halt_cause, o_retire_count, o_last_pc);
        end
    endtask

    task automatic test_self_loop();
        clear_stim();
        for (int j = 1; j <= 8; j++) begin
            s_vld[j] = 1'b1; s_pc[j] = 32'h20; s_instr[j] = NOP;
        end
        i_end_pc_en = 1'b0;
        model();
        do_run(term);
        vec++;
        if (term !== 4 || o_halt_cause !== 3'd3 || o_retire_count !== 4 || o_last_pc !== 32'h20) begin
            errs++;
            $display("FAIL self_loop: term=%0d cause=%0d ret=%0d last=%h, want 4 3 4 20",
                     term, o_halt_cause, o_retire_count, o_last_pc);
        end
    endtask

    task automatic test_timeout();
        clear_stim();
        i_end_pc_en = 1'b0;
        model();
        do_run(term);
        vec++;
        if (term !== MAXC || o_halt_cause !== 3'd4 || o_cycle_count !== MAXC || o_retire_count !== 0) begin
            errs++;
            $display("FAIL timeout: term=%0d cause=%0d cyc=%0d ret=%0d, want %0d 4 %0d 0",
                     term, o_halt_cause, o_cycle_count, o_retire_count, MAXC, MAXC);
        end
    endtask

    task automatic test_priority();
        clear_stim();
        s_vld[1] = 1'b1; s_pc[1] = 32'h10; s_instr[1] = SYS;
        i_end_pc = 32'h10; i_end_pc_en = 1'b1;
        model();
        do_run(term);
        vec++;
        if (term !== 1 || o_halt_cause !== 3'd1 || o_retire_count !== 1) begin
            errs++;
            $display("FAIL priority: term=%0d cause=%0d ret=%0d, want 1 1 1",
                     term, o_halt_cause, o_retire_count);
        end
    endtask

    task automatic test_start_in_run();
        load_end_pc_prog();
        s_start[2] = 1'b1; s_start[3] = 1'b1;
        model();
        do_run(term);
        vec++;
        if (term !== 5 || o_halt_cause !== 3'd1 || o_cycle_count !== 5 || o_retire_count !== 5) begin
            errs++;
            $display("FAIL start_in_run: term=%0d cause=%0d cyc=%0d ret=%0d, want 5 1 5 5",
                     term, o_halt_cause, o_cycle_count, o_retire_count);
        end
    endtask

    task automatic test_reset_mid_run();
        i_start = 1'b1; i_instr_valid = 1'b0; i_end_pc_en = 1'b0;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (49) @(posedge i_clk);
        #1;
        vec++;
        if (o_busy !== 1'b1 || o_cycle_count !== 49) begin
            errs++;
            $display("FAIL pre_abort: busy=%b cyc=%0d, want 1 49", o_busy, o_cycle_count);
        end
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        m_last = '0;
        vec++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_halt_cause !== 3'd0 ||
            o_cycle_count !== 0 || o_retire_count !== 0) begin
            errs++;
            $display("FAIL abort: busy=%b done=%b cause=%0d cyc=%0d ret=%0d, want all zero",
                     o_busy, o_done, o_halt_cause, o_cycle_count, o_retire_count);
        end
        load_end_pc_prog();
        model();
        do_run(term);
        vec++;
        if (term !== 5 || o_halt_cause !== 3'd1 || o_cycle_count !== 5) begin
            errs++;
            $display("FAIL after_abort: term=%0d cause=%0d cyc=%0d, want 5 1 5",
                     term, o_halt_cause, o_cycle_count);
        end
`ifdef CALC_RUN_MONITOR_SIG_EN
        sig_a = o_signature;
        vec++;
        if (sig_a !== m_sig) begin
            errs++;
            $display("FAIL sig_model: got %h want %h", sig_a, m_sig);
        end
        do_run(term);
        vec++;
        if (o_signature !== sig_a) begin
            errs++;
            $display("FAIL sig_repeat: got %h want %h", o_signature, sig_a);
        end
`endif
    endtask

    task automatic test_random();
        for (int r = 0; r < 30; r++) begin
            int vld_pct;
            clear_stim();
            vld_pct = (r % 5 == 0) ? 3 : 70;
            for (int j = 1; j < 256; j++) begin
                s_vld[j]   = ($urandom_range(0, 99) < vld_pct);
                s_pc[j]    = 32'($urandom_range(0, 3) * 4);
                s_instr[j] = ($urandom_range(0, 11) == 0) ? SYS : $urandom;
                s_start[j] = ($urandom_range(0, 9) == 0);
            end
            i_end_pc    = 32'($urandom_range(0, 7) * 4);
            i_end_pc_en = $urandom_range(0, 1);
            model();
            do_run(term);
            vec++;
            if (term !== m_term || o_halt_cause !== 3'(m_cause) || o_cycle_count !== m_cyc ||
                o_retire_count !== m_ret || o_last_pc !== m_last || o_busy !== 1'b0) begin
                errs++;
                $display("FAIL random[%0d]: term=%0d cause=%0d cyc=%0d ret=%0d last=%h busy=%b, want %0d %0d %0d %0d %h 0",
                         r, term, o_halt_cause, o_cycle_count, o_retire_count, o_last_pc, o_busy,
                         m_term, m_cause, m_cyc, m_ret, m_last);
            end
`ifdef CALC_RUN_MONITOR_SIG_EN
            vec++;
            if (o_signature !== m_sig) begin
                errs++;
                $display("FAIL random_sig[%0d]: got %h want %h", r, o_signature, m_sig);
            end
`endif
        end
    endtask

    initial begin
        clear_stim();
        test_reset();
        test_end_pc();
        test_syscall();
        test_self_loop();
        test_timeout();
        test_priority();
        test_start_in_run();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
